mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Time-slices the single-port unified memory between the CPU and the VGA scanout reader.
- Generates the CPU controller's pre_en/en enables and drives the mem_src select plus the memory address/write mux.
- The CPU freezes whenever en=0. Slot boundaries are therefore always safe, and the CPU needs no knowledge of the VGA.

Parameters:
- WORD_SIZE, 32, data width.
- ADDR_WIDTH, 16, memory word-address width.
- CPU_SLOT, 4, en-high cycles granted per CPU window (1..15).
- VGA_BURST, 8, maximum consecutive VGA grants per window (1..15).
- VGA_MAX_WAIT, 6, cycles a VGA request may wait during a CPU window before preemption (1..15).

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_run  in  1  CPU allowed to execute (0 = halted).
- cpu_addr  in  ADDR_WIDTH  CPU memory address.
- cpu_we  in  1  CPU write strobe.
- cpu_wdata  in  WORD_SIZE  CPU write data.
- vga_req  in  1  VGA wants a word.
- vga_addr  in  ADDR_WIDTH  VGA read address.
- vga_gnt  out  1  VGA address accepted this cycle.
- vga_rvalid  out  1  mem_rdata holds VGA word.
- pre_en  out  1  CPU pre-enable (one cycle before en).
- en  out  1  CPU step enable.
- mem_src  out  1  SRC_CPU / SRC_VGA.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_we  out  1  memory write enable.
- mem_wdata  out  WORD_SIZE  memory write data.

Behaviour:
- Reset (asynchronous, resetn=0):
  - state=IDLE; all counters 0.
  - vga_gnt, vga_rvalid, pre_en, en and mem_we are 0.
  - mem_src=SRC_VGA; mem_addr=0; mem_wdata=0.
- FSM states: IDLE, CPU_PRE, CPU_RUN, VGA.
- IDLE:
  - If vga_req=1, go to VGA. VGA wins a tie with cpu_run.
  - Else if cpu_run=1, go to CPU_PRE.
  - Else stay in IDLE.
- CPU_PRE:
  - Outputs: pre_en=1, en=0, mem_src=SRC_CPU, mem_addr=cpu_addr, mem_we=0.
  - Always lasts exactly 1 cycle, then goes to CPU_RUN with slot_cnt=0.
- CPU_RUN:
  - Outputs: en=1, mem_src=SRC_CPU, mem_addr=cpu_addr, mem_we=cpu_we, mem_wdata=cpu_wdata.
  - slot_cnt increments each cycle.
  - wait_cnt increments while vga_req=1 and clears when vga_req=0.
  - Exit when slot_cnt==CPU_SLOT-1, or wait_cnt==VGA_MAX_WAIT-1, or cpu_run=0.
  - Exit target: VGA if vga_req=1, else CPU_PRE if cpu_run=1, else IDLE.
  - en stays 1 in the exit cycle.
  - If cpu_run drops, en=0 in that same cycle (combinational gate), then exit.
- VGA:
  - Outputs: mem_src=SRC_VGA, mem_addr=vga_addr, mem_we=0 (VGA never writes), vga_gnt=vga_req.
  - burst_cnt increments on each grant.
  - Exit when vga_req=0 or burst_cnt==VGA_BURST-1. Exit target: CPU_PRE if cpu_run=1, else IDLE.
- vga_rvalid equals vga_gnt delayed by one registered cycle (synchronous RAM latency 1). It is independent of the next state's mem_src.
- Interleaving: pre_en and en are never high together. en is never high unless the previous active cycle was CPU_PRE or CPU_RUN. Every CPU resume after VGA or IDLE passes through CPU_PRE, so load addresses are re-presented.
- cpu_we while en=0 is ignored (mem_we=0).
- Counters saturate and never wrap. All are cleared on state entry.
- Reset mid-window: all outputs return to reset values immediately. The CPU controller's own reset covers its state.

Decomposition:
- SRC_CPU/SRC_VGA come from control_signals.vh. WORD_SIZE/ADDR_WIDTH come from parameters.vh.
- Add the FSM state encodings (ARB_IDLE, ARB_CPU_PRE, ARB_CPU_RUN, ARB_VGA) to control_signals.vh.
- One sub-module, arb_sat_counter: a 4-bit saturating counter with clear/inc/limit. Instantiated three times (slot, wait, burst).

Test Plan:
- Reset, then cpu_run=1 with vga_req=0 → pre_en high in cycle 1; en high in cycles 2-5 (CPU_SLOT=4); pre_en high in cycle 6; pattern repeats; vga_gnt stays 0.
- vga_req and cpu_run both rise in IDLE → VGA first. With vga_req held, vga_gnt high for 8 cycles, vga_rvalid high for 8 cycles lagging by 1, then pre_en.
- vga_req raised in the 2nd en cycle of a CPU window → window runs its full 4 en cycles (ends before wait reaches 6); next cycle mem_src=SRC_VGA with mem_addr=vga_addr.
- CPU_SLOT=15, VGA_MAX_WAIT=3, vga_req raised in the 1st en cycle → en lasts 3 cycles, then VGA preempts; after the burst, pre_en precedes en again.
- cpu_we=1 with cpu_addr=0x0010 and cpu_wdata=0xDEADBEEF in CPU_RUN → mem_we=1 and mem_addr=0x0010 that cycle. cpu_we=1 held during VGA or CPU_PRE → mem_we=0.
- resetn pulsed low in the 2nd en cycle → en, pre_en and vga_gnt drop to 0 asynchronously. After release, IDLE, then CPU_PRE.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_pkg
// Description : Shared constants, memory-source select codes and arbiter
//               FSM state encodings for the unified-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

  // Default bus geometry of the unified memory
  localparam int MEM_WORD_SIZE  = 32;
  localparam int MEM_ADDR_WIDTH = 16;

  // Width of the slot / wait / burst counters (limits are 1..15)
  localparam int CNT_W = 4;

  // Memory source select
  localparam logic SRC_CPU = 1'b0;
  localparam logic SRC_VGA = 1'b1;

  // Arbiter FSM states
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_CPU_PRE = 2'd1,
    ARB_CPU_RUN = 2'd2,
    ARB_VGA     = 2'd3
  } arb_state_t;

  // Terminal count for a window of n cycles (counters run 0..n-1)
  function automatic logic [CNT_W-1:0] cnt_limit(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter_if
// Description : CPU / VGA / memory-side signal bundle of the memory arbiter.
//               slave  = arbiter view, master = surrounding system view.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE  = MEM_WORD_SIZE,
  parameter int ADDR_WIDTH = MEM_ADDR_WIDTH
);

  // CPU side
  logic                  cpu_run;
  logic [ADDR_WIDTH-1:0] cpu_addr;
  logic                  cpu_we;
  logic [WORD_SIZE-1:0]  cpu_wdata;
  logic                  pre_en;
  logic                  en;

  // VGA scanout side
  logic                  vga_req;
  logic [ADDR_WIDTH-1:0] vga_addr;
  logic                  vga_gnt;
  logic                  vga_rvalid;

  // Memory side
  logic                  mem_src;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [WORD_SIZE-1:0]  mem_wdata;

  modport slave (
    input  cpu_run, cpu_addr, cpu_we, cpu_wdata, vga_req, vga_addr,
    output pre_en, en, vga_gnt, vga_rvalid, mem_src, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output cpu_run, cpu_addr, cpu_we, cpu_wdata, vga_req, vga_addr,
    input  pre_en, en, vga_gnt, vga_rvalid, mem_src, mem_addr, mem_we, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/arb_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : arb_sat_counter
// Description : Small saturating up-counter with synchronous clear. Holds at
//               'limit' instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_sat_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  // Clear has priority; increment stops once the limit is reached
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != limit)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Time-slices the single-port unified memory between the CPU
//               and the VGA scanout reader. The CPU only advances while en=1,
//               so every slot boundary is a safe switch point; pre_en gives
//               the CPU one cycle to re-present its address before en.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WORD_SIZE    = MEM_WORD_SIZE,
  parameter int ADDR_WIDTH   = MEM_ADDR_WIDTH,
  parameter int CPU_SLOT     = 4,
  parameter int VGA_BURST    = 8,
  parameter int VGA_MAX_WAIT = 6
) (
  input  logic         clk,
  input  logic         resetn,
  mem_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] c_slot_lim  = cnt_limit(CPU_SLOT);
  localparam logic [CNT_W-1:0] c_wait_lim  = cnt_limit(VGA_MAX_WAIT);
  localparam logic [CNT_W-1:0] c_burst_lim = cnt_limit(VGA_BURST);

  arb_state_t            r_state;
  arb_state_t            w_state_next;
  logic                  r_vga_rvalid;

  logic [CNT_W-1:0]      w_slot_cnt;
  logic [CNT_W-1:0]      w_wait_cnt;
  logic [CNT_W-1:0]      w_burst_cnt;
  logic                  w_keep_run;
  logic                  w_keep_vga;

  logic                  w_pre_en;
  logic                  w_en;
  logic                  w_vga_gnt;
  logic                  w_mem_src;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic                  w_mem_we;
  logic [WORD_SIZE-1:0]  w_mem_wdata;

  // State register; reset parks the arbiter idle with memory on the VGA side
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and output decode; all outputs default to their reset values
  always_comb begin
    w_state_next = r_state;
    w_pre_en     = 1'b0;
    w_en         = 1'b0;
    w_vga_gnt    = 1'b0;
    w_mem_src    = SRC_VGA;
    w_mem_addr   = '0;
    w_mem_we     = 1'b0;
    w_mem_wdata  = '0;

    case (r_state)
      ARB_IDLE: begin
        // VGA wins a simultaneous request
        if (bus.vga_req) begin
          w_state_next = ARB_VGA;
        end else if (bus.cpu_run) begin
          w_state_next = ARB_CPU_PRE;
        end
      end

      ARB_CPU_PRE: begin
        w_pre_en     = 1'b1;
        w_mem_src    = SRC_CPU;
        w_mem_addr   = bus.cpu_addr;
        w_state_next = ARB_CPU_RUN;
      end

      ARB_CPU_RUN: begin
        // Gating en with cpu_run freezes the CPU in the very cycle it halts;
        // the same gate keeps a halted CPU from writing.
        w_en        = bus.cpu_run;
        w_mem_src   = SRC_CPU;
        w_mem_addr  = bus.cpu_addr;
        w_mem_we    = bus.cpu_we & bus.cpu_run;
        w_mem_wdata = bus.cpu_wdata;
        if ((w_slot_cnt == c_slot_lim) || (w_wait_cnt == c_wait_lim) || !bus.cpu_run) begin
          if (bus.vga_req) begin
            w_state_next = ARB_VGA;
          end else if (bus.cpu_run) begin
            w_state_next = ARB_CPU_PRE;
          end else begin
            w_state_next = ARB_IDLE;
          end
        end
      end

      ARB_VGA: begin
        w_vga_gnt  = bus.vga_req;
        w_mem_src  = SRC_VGA;
        w_mem_addr = bus.vga_addr;
        if (!bus.vga_req || (w_burst_cnt == c_burst_lim)) begin
          w_state_next = bus.cpu_run ? ARB_CPU_PRE : ARB_IDLE;
        end
      end

      default: begin
        w_state_next = ARB_IDLE;
      end
    endcase
  end

  // Counters restart on every state entry, i.e. whenever the state is not held
  assign w_keep_run = (r_state == ARB_CPU_RUN) && (w_state_next == ARB_CPU_RUN);
  assign w_keep_vga = (r_state == ARB_VGA) && (w_state_next == ARB_VGA);

  arb_sat_counter #(.WIDTH(CNT_W)) u_slot_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!w_keep_run),
    .inc    (1'b1),
    .limit  (c_slot_lim),
    .count  (w_slot_cnt)
  );

  // Counts consecutive waiting cycles of a VGA request during a CPU window
  arb_sat_counter #(.WIDTH(CNT_W)) u_wait_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!w_keep_run || !bus.vga_req),
    .inc    (bus.vga_req),
    .limit  (c_wait_lim),
    .count  (w_wait_cnt)
  );

  arb_sat_counter #(.WIDTH(CNT_W)) u_burst_cnt (
    .clk    (clk),
    .resetn (resetn),
    .clr    (!w_keep_vga),
    .inc    (w_vga_gnt),
    .limit  (c_burst_lim),
    .count  (w_burst_cnt)
  );

  // Read data follows a grant by one cycle (synchronous RAM latency)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_vga_rvalid <= 1'b0;
    end else begin
      r_vga_rvalid <= w_vga_gnt;
    end
  end

  assign bus.pre_en     = w_pre_en;
  assign bus.en         = w_en;
  assign bus.vga_gnt    = w_vga_gnt;
  assign bus.vga_rvalid = r_vga_rvalid;
  assign bus.mem_src    = w_mem_src;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_we     = w_mem_we;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule
`default_nettype wire
